// File: rtl/fifo_pkg.sv
// Shared FIFO pointer helpers and default geometry, common to the write- and read-side
// controllers.
package fifo_pkg;

   localparam int unsigned ADDR_W_DEF   = 3;
   localparam int unsigned AFULL_TH_DEF = 2;
   localparam int unsigned PTR_MAX_W    = 32;

   function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Callers zero-extend narrower pointers, which leaves the low bits unaffected.
   function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] gray);
      logic [PTR_MAX_W-1:0] bin;
      bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
      for (int i = int'(PTR_MAX_W) - 2; i >= 0; i--) begin
         bin[i] = bin[i+1] ^ gray[i];
      end
      return bin;
   endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter of configurable width.
module fifo_gray2bin
   import fifo_pkg::*;
#(
   parameter int unsigned WIDTH = ADDR_W_DEF + 1
) (
   input  logic [WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0] bin_o
);

   assign bin_o = WIDTH'(gray2bin(PTR_MAX_W'(gray_i)));

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO: write pointer, full/almost-full, free count
// and sticky overflow flag, all in the write clock domain.
module fifo_wr_ctrl
   import fifo_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned AFULL_TH = AFULL_TH_DEF
) (
   input  logic              w_clk,
   input  logic              w_rst,
   input  logic              w_inc,
   input  logic [ADDR_W:0]   gray_r_ptr,
   input  logic              w_ovf_clr,
   output logic              w_en,
   output logic [ADDR_W-1:0] w_addr,
   output logic [ADDR_W:0]   gray_w_ptr,
   output logic              w_full,
   output logic              w_afull,
   output logic [ADDR_W:0]   w_free,
   output logic              w_ovf
);

   localparam int unsigned     PTR_W     = ADDR_W + 1;
   localparam logic [ADDR_W:0] DEPTH     = PTR_W'(2 ** ADDR_W);
   localparam logic            AFULL_RST = ((2 ** ADDR_W) <= AFULL_TH);

   logic [ADDR_W:0] wbin_q, wbin_d;
   logic [ADDR_W:0] wgray_q, wgray_d;
   logic [ADDR_W:0] free_q, free_d;
   logic [ADDR_W:0] rbin;
   logic            full_q, full_d;
   logic            afull_q, afull_d;
   logic            ovf_q, ovf_d;

   fifo_gray2bin #(
      .WIDTH (PTR_W)
   ) u_r_gray2bin (
      .gray_i (gray_r_ptr),
      .bin_o  (rbin)
   );

   assign w_en = w_inc & ~full_q & ~w_rst;

   // Flags are computed from the post-edge pointer so they never lag a write.
   always_comb begin
      wbin_d  = wbin_q + PTR_W'(w_en);
      wgray_d = PTR_W'(bin2gray(PTR_MAX_W'(wbin_d)));
      full_d  = (wgray_d == {~gray_r_ptr[ADDR_W -: 2], gray_r_ptr[ADDR_W-2:0]});
      free_d  = DEPTH - (wbin_d - rbin);
      afull_d = (PTR_MAX_W'(free_d) <= AFULL_TH);
      ovf_d   = (w_inc & full_q) | (ovf_q & ~w_ovf_clr);
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         wbin_q  <= '0;
         wgray_q <= '0;
         full_q  <= 1'b0;
         free_q  <= DEPTH;
         afull_q <= AFULL_RST;
         ovf_q   <= 1'b0;
      end else begin
         wbin_q  <= wbin_d;
         wgray_q <= wgray_d;
         full_q  <= full_d;
         free_q  <= free_d;
         afull_q <= afull_d;
         ovf_q   <= ovf_d;
      end
   end

   assign w_addr     = wbin_q[ADDR_W-1:0];
   assign gray_w_ptr = wgray_q;
   assign w_full     = full_q;
   assign w_afull    = afull_q;
   assign w_free     = free_q;
   assign w_ovf      = ovf_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed vector table plus randomized run against an occupancy-based reference model.
module tb_fifo_wr_ctrl;

   localparam int DEPTH    = 8;
   localparam int AFULL_TH = 2;

   logic       w_clk = 1'b0;
   logic       w_rst, w_inc, w_ovf_clr;
   logic [3:0] gray_r_ptr;
   logic       w_en, w_full, w_afull, w_ovf;
   logic [2:0] w_addr;
   logic [3:0] gray_w_ptr, w_free;

   int n_checks = 0;
   int n_pass   = 0;

   fifo_wr_ctrl #(
      .ADDR_W   (3),
      .AFULL_TH (2)
   ) dut (
      .w_clk      (w_clk),
      .w_rst      (w_rst),
      .w_inc      (w_inc),
      .gray_r_ptr (gray_r_ptr),
      .w_ovf_clr  (w_ovf_clr),
      .w_en       (w_en),
      .w_addr     (w_addr),
      .gray_w_ptr (gray_w_ptr),
      .w_full     (w_full),
      .w_afull    (w_afull),
      .w_free     (w_free),
      .w_ovf      (w_ovf)
   );

   always #5 w_clk = ~w_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int rst, inc, rg, clr;
      int en, addr, gray, full, free, afull, ovf;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(int rst, int inc, int rg, int clr, int en, int addr, int gray,
                               int full, int free, int afull, int ovf);
      vec_t v;
      v.rst = rst; v.inc = inc; v.rg = rg; v.clr = clr;
      v.en = en; v.addr = addr; v.gray = gray; v.full = full;
      v.free = free; v.afull = afull; v.ovf = ovf;
      return v;
   endfunction

   function automatic int gray_of(int b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic chk_outs(input string tag, input int addr, input int gray, input int full,
                           input int free, input int afull, input int ovf);
      chk({tag, " w_addr"}, 32'(w_addr), addr);
      chk({tag, " gray_w_ptr"}, 32'(gray_w_ptr), gray);
      chk({tag, " w_full"}, 32'(w_full), full);
      chk({tag, " w_free"}, 32'(w_free), free);
      chk({tag, " w_afull"}, 32'(w_afull), afull);
      chk({tag, " w_ovf"}, 32'(w_ovf), ovf);
   endtask

   int  m_w, m_r, occ, exp_en, exp_free;
   bit  m_full, m_ovf, r_rst, r_inc, r_clr;

   initial begin
      w_rst = 1'b1; w_inc = 1'b0; w_ovf_clr = 1'b0; gray_r_ptr = 4'd0;

      // Reset, fill to full, overflow, read frees space, refill, clear vs set, wrap, reset.
      tbl.push_back(mk(1, 1, 4'b0000, 0,  0, 0, 4'b0000, 0, 8, 0, 0));
      tbl.push_back(mk(1, 0, 4'b0000, 0,  0, 0, 4'b0000, 0, 8, 0, 0));
      tbl.push_back(mk(0, 1, 4'b0000, 0,  1, 1, 4'b0001, 0, 7, 0, 0));
      tbl.push_back(mk(0, 1, 4'b0000, 0,  1, 2, 4'b0011, 0, 6, 0, 0));
      tbl.push_back(mk(0, 1, 4'b0000, 0,  1, 3, 4'b0010, 0, 5, 0, 0));
      tbl.push_back(mk(0, 1, 4'b0000, 0,  1, 4, 4'b0110, 0, 4, 0, 0));
      tbl.push_back(mk(0, 1, 4'b0000, 0,  1, 5, 4'b0111, 0, 3, 0, 0));
      tbl.push_back(mk(0, 1, 4'b0000, 0,  1, 6, 4'b0101, 0, 2, 1, 0));
      tbl.push_back(mk(0, 1, 4'b0000, 0,  1, 7, 4'b0100, 0, 1, 1, 0));
      tbl.push_back(mk(0, 1, 4'b0000, 0,  1, 0, 4'b1100, 1, 0, 1, 0));
      for (int i = 0; i < 5; i++)
         tbl.push_back(mk(0, 1, 4'b0000, 0,  0, 0, 4'b1100, 1, 0, 1, 1));
      tbl.push_back(mk(0, 0, 4'b0111, 0,  0, 0, 4'b1100, 0, 5, 0, 1));
      tbl.push_back(mk(0, 1, 4'b0111, 0,  1, 1, 4'b1101, 0, 4, 0, 1));
      tbl.push_back(mk(0, 1, 4'b0111, 0,  1, 2, 4'b1111, 0, 3, 0, 1));
      tbl.push_back(mk(0, 1, 4'b0111, 0,  1, 3, 4'b1110, 0, 2, 1, 1));
      tbl.push_back(mk(0, 1, 4'b0111, 0,  1, 4, 4'b1010, 0, 1, 1, 1));
      tbl.push_back(mk(0, 1, 4'b0111, 0,  1, 5, 4'b1011, 1, 0, 1, 1));
      tbl.push_back(mk(0, 1, 4'b1011, 0,  0, 5, 4'b1011, 0, 8, 0, 1));
      tbl.push_back(mk(0, 1, 4'b1011, 0,  1, 6, 4'b1001, 0, 7, 0, 1));
      tbl.push_back(mk(0, 1, 4'b1011, 0,  1, 7, 4'b1000, 0, 6, 0, 1));
      tbl.push_back(mk(0, 1, 4'b1011, 0,  1, 0, 4'b0000, 0, 5, 0, 1));
      tbl.push_back(mk(0, 1, 4'b1011, 0,  1, 1, 4'b0001, 0, 4, 0, 1));
      tbl.push_back(mk(0, 1, 4'b1011, 0,  1, 2, 4'b0011, 0, 3, 0, 1));
      tbl.push_back(mk(0, 1, 4'b1011, 0,  1, 3, 4'b0010, 0, 2, 1, 1));
      tbl.push_back(mk(0, 1, 4'b1011, 0,  1, 4, 4'b0110, 0, 1, 1, 1));
      tbl.push_back(mk(0, 1, 4'b1011, 0,  1, 5, 4'b0111, 1, 0, 1, 1));
      tbl.push_back(mk(0, 1, 4'b1011, 1,  0, 5, 4'b0111, 1, 0, 1, 1));
      tbl.push_back(mk(0, 0, 4'b1011, 1,  0, 5, 4'b0111, 1, 0, 1, 0));
      tbl.push_back(mk(0, 1, 4'b1011, 0,  0, 5, 4'b0111, 1, 0, 1, 1));
      tbl.push_back(mk(1, 1, 4'b1011, 1,  0, 0, 4'b0000, 0, 8, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         w_rst      = tbl[i].rst[0];
         w_inc      = tbl[i].inc[0];
         gray_r_ptr = tbl[i].rg[3:0];
         w_ovf_clr  = tbl[i].clr[0];
         #1;
         chk($sformatf("row%0d w_en", i), 32'(w_en), tbl[i].en);
         @(posedge w_clk);
         #1;
         chk_outs($sformatf("row%0d", i), tbl[i].addr, tbl[i].gray, tbl[i].full,
                  tbl[i].free, tbl[i].afull, tbl[i].ovf);
      end

      // Model: pointers as plain counters mod 16; occupancy decides full/free.
      m_w = 0; m_r = 0; m_full = 1'b0; m_ovf = 1'b0;
      for (int c = 0; c < 600; c++) begin
         r_rst = ($urandom_range(0, 63) == 0);
         r_inc = ($urandom_range(0, 3) != 0);
         r_clr = ($urandom_range(0, 7) == 0);
         occ   = (m_w - m_r + 16) % 16;
         if (r_rst) m_r = 0;
         else if ($urandom_range(0, 2) == 0) m_r = (m_r + int'($urandom_range(0, occ))) % 16;

         w_rst = r_rst; w_inc = r_inc; w_ovf_clr = r_clr;
         gray_r_ptr = 4'(gray_of(m_r));
         #1;
         exp_en = (r_inc && !m_full && !r_rst) ? 1 : 0;
         chk($sformatf("rand%0d w_en", c), 32'(w_en), exp_en);
         @(posedge w_clk);
         #1;
         if (r_rst) begin
            m_w = 0; m_ovf = 1'b0;
         end else begin
            m_ovf = (r_inc && m_full) || (m_ovf && !r_clr);
            if (exp_en == 1) m_w = (m_w + 1) % 16;
         end
         occ      = (m_w - m_r + 16) % 16;
         m_full   = (occ == DEPTH);
         exp_free = DEPTH - occ;
         chk_outs($sformatf("rand%0d", c), m_w % DEPTH, gray_of(m_w), int'(m_full), exp_free,
                  (exp_free <= AFULL_TH) ? 1 : 0, int'(m_ovf));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 3, address width (DEPTH = 2**ADDR_W); AFULL_TH, default 2, almost-full threshold in free entries.
REQ-002 w_clk  in  1  write-domain clock; single clock, all state on rising edge.
REQ-003 w_rst  in  1  reset, synchronous, active-high.
REQ-004 w_inc  in  1  write request for current cycle.
REQ-005 gray_r_ptr  in  ADDR_W+1  read pointer, Gray-coded, already synchronised into w_clk domain.
REQ-006 w_ovf_clr  in  1  clears sticky overflow flag.
REQ-007 w_en  out  1  memory write strobe = w_inc & ~w_full (only combinational output).
REQ-008 w_addr  out  ADDR_W  memory write address, lower ADDR_W bits of binary write pointer.
REQ-009 gray_w_ptr  out  ADDR_W+1  registered Gray-coded write pointer for the read-side synchroniser.
REQ-010 w_full  out  1  FIFO full, registered.
REQ-011 w_afull  out  1  almost full, registered, high when w_free <= AFULL_TH.
REQ-012 w_free  out  ADDR_W+1  free entries, 0..DEPTH, registered.
REQ-013 w_ovf  out  1  sticky: a write was attempted while full.

Function
REQ-014 Binary write pointer SHALL be ADDR_W+1 bits and increment by 1 at each edge where w_en=1, wrapping modulo 2**(ADDR_W+1).
REQ-015 gray_w_ptr SHALL equal bin2gray of the binary pointer, updated at the same edge (no extra latency).
REQ-016 w_full SHALL be registered as (next Gray pointer == {~gray_r_ptr[ADDR_W:ADDR_W-1], gray_r_ptr[ADDR_W-2:0]}), sampled each edge.
REQ-017 w_free SHALL be registered as DEPTH - ((next_wbin - gray2bin(gray_r_ptr)) mod 2**(ADDR_W+1)), all arithmetic in ADDR_W+1 bits.
REQ-018 w_full and w_free SHALL be re-evaluated every edge, so read-pointer advance with no write frees space one edge later.
REQ-019 w_inc while w_full=1 SHALL leave pointer, w_addr, gray_w_ptr unchanged and set w_ovf at that edge.
REQ-020 w_ovf SHALL clear on w_ovf_clr=1; simultaneous clear and new overflow SHALL leave w_ovf=1 (set wins).
REQ-021 w_full=1 SHALL imply w_free=0 and w_afull=1 in the same cycle.
REQ-022 Non-Gray-adjacent changes on gray_r_ptr SHALL be accepted without checking; behaviour stays defined per REQ-016/017.

Reset
REQ-023 While w_rst=1 at an edge: binary pointer=0, w_addr=0, gray_w_ptr=0, w_full=0, w_free=DEPTH, w_afull=(DEPTH<=AFULL_TH), w_ovf=0.
REQ-024 Reset SHALL override w_inc and w_ovf_clr; w_en SHALL be 0 during reset.
REQ-025 Reset asserted mid-operation SHALL return to REQ-023 values in one edge regardless of fill level.

Structure
REQ-026 Shared package fifo_pkg SHALL hold default ADDR_W, AFULL_TH and functions bin2gray/gray2bin, shared with the read-side controller.
REQ-027 Gray-to-binary conversion of gray_r_ptr SHALL be one sub-module, fifo_gray2bin, parametrised by width.
REQ-028 Block SHALL contain no memory and no synchronisers.

Verification (ADDR_W=3, AFULL_TH=2)
REQ-029 Reset 2 cycles -> w_addr=0, gray_w_ptr=4'b0000, w_full=0, w_free=8, w_afull=0, w_ovf=0.
REQ-030 gray_r_ptr=0, w_inc=1 for 8 cycles -> w_afull=1 after 6th edge (w_free=2); after 8th edge w_full=1, w_free=0, gray_w_ptr=4'b1100, w_addr=0.
REQ-031 Continue w_inc=1 for 5 more cycles while full -> w_en=0, gray_w_ptr stays 4'b1100, w_ovf=1 and stays 1.
REQ-032 Then w_inc=0, gray_r_ptr=4'b0111 (binary 5) -> next edge w_full=0, w_free=5, w_afull=0.
REQ-033 Write until binary pointer wraps 15->0 with reads tracking -> gray_w_ptr goes 4'b1000 -> 4'b0000, w_free correct across wrap.
REQ-034 w_ovf_clr=1 on an edge with overflow write -> w_ovf stays 1; w_rst=1 while full -> all outputs to REQ-023 values next edge.
